// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with one 2-bit saturating counter per
// entry. The fetch-stage lookup is combinational. The EX stage resolves each
// branch, raises a redirect request, updates the table and keeps branch and
// mispredict statistics.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        CPU_RSTn,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        ValidE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BrCount,
  output logic [31:0] MispCount
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [N];
  logic [TAG_W-1:0] tag_q    [N];
  logic [31:0]      target_q [N];
  logic [1:0]       ctr_q    [N];
  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      misp_cnt_q, misp_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e, is_br, upd;

  logic             wr_en;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;
  logic [1:0]       ctr_d;

  // The two low PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign is_br = (BranchTypeE != 3'd0);
  assign upd   = ValidE && !StallE;

  // Fetch lookup sees only registered contents, so a same-cycle update shows up next cycle.
  always_comb begin
    PredTakenF  = hit_f && ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : 32'd0;
  end

  // Redirect decision for the instruction currently in EX.
  always_comb begin
    MispredE = ValidE && (
                 (is_br && (BranchE != PredTakenE)) ||
                 (is_br && BranchE && PredTakenE && (PredTargetE != BrTargetE)) ||
                 (!is_br && PredTakenE));
    CorrectPCE = (is_br && BranchE) ? BrTargetE : (PCE + 32'd4);
  end

  // Next contents of the single entry addressed by PCE.
  always_comb begin
    wr_en    = 1'b0;
    valid_d  = valid_q[idx_e];
    tag_d    = tag_q[idx_e];
    target_d = target_q[idx_e];
    ctr_d    = ctr_q[idx_e];
    if (upd) begin
      if (is_br) begin
        if (hit_e) begin
          wr_en = 1'b1;
          if (BranchE) begin
            target_d = BrTargetE;
            if (ctr_q[idx_e] != 2'b11) ctr_d = ctr_q[idx_e] + 2'd1;
          end else if (ctr_q[idx_e] != 2'b00) begin
            ctr_d = ctr_q[idx_e] - 2'd1;
          end
        end else if (BranchE) begin
          // Allocate on a taken miss; starts weakly taken.
          wr_en    = 1'b1;
          valid_d  = 1'b1;
          tag_d    = tag_e;
          target_d = BrTargetE;
          ctr_d    = 2'b10;
        end
      end else if (hit_e) begin
        // A non-branch aliasing onto an entry would keep predicting a bogus redirect.
        wr_en   = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  // Statistics, both saturating at all-ones.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (upd && is_br && (br_cnt_q != 32'hFFFF_FFFF))       br_cnt_d   = br_cnt_q + 32'd1;
    if (upd && MispredE && (misp_cnt_q != 32'hFFFF_FFFF)) misp_cnt_d = misp_cnt_q + 32'd1;
  end

  // Table storage; reset wipes every entry so an in-flight update is lost.
  always_ff @(posedge CLK or negedge CPU_RSTn) begin
    if (!CPU_RSTn) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[idx_e]  <= valid_d;
      tag_q[idx_e]    <= tag_d;
      target_q[idx_e] <= target_d;
      ctr_q[idx_e]    <= ctr_d;
    end
  end

  // Statistic registers.
  always_ff @(posedge CLK or negedge CPU_RSTn) begin
    if (!CPU_RSTn) begin
      br_cnt_q   <= 32'd0;
      misp_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign BrCount   = br_cnt_q;
  assign MispCount = misp_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (IDX_W=4: 0x100, 0x140, 0x180 share index 0).
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        CPU_RSTn;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        ValidE, StallE;
  logic [31:0] PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredE;
  logic [31:0] CorrectPCE, BrCount, MispCount;

  int vectors = 0;
  int miscompares = 0;

  branch_predictor #(.IDX_W(4)) dut (
    .CLK(CLK), .CPU_RSTn(CPU_RSTn), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .ValidE(ValidE), .StallE(StallE), .PCE(PCE), .BranchTypeE(BranchTypeE),
    .BranchE(BranchE), .BrTargetE(BrTargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredE(MispredE), .CorrectPCE(CorrectPCE),
    .BrCount(BrCount), .MispCount(MispCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic v, input logic s, input logic [31:0] pc, input logic [2:0] bt,
                    input logic taken, input logic [31:0] tgt, input logic ptk,
                    input logic [31:0] ptgt);
    ValidE = v; StallE = s; PCE = pc; BranchTypeE = bt;
    BranchE = taken; BrTargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
    #1;
  endtask

  task automatic idle();
    ex(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt);
    PCF = pc;
    #1;
    chk({tag, "_tk"}, {31'd0, PredTakenF}, {31'd0, tk});
    chk({tag, "_tgt"}, PredTargetF, tgt);
  endtask

  task automatic cnts(input string tag, input logic [31:0] br, input logic [31:0] mp);
    chk({tag, "_br"}, BrCount, br);
    chk({tag, "_misp"}, MispCount, mp);
  endtask

  task automatic redir(input string tag, input logic mp, input logic [31:0] cpc);
    chk({tag, "_mp"}, {31'd0, MispredE}, {31'd0, mp});
    if (mp) chk({tag, "_cpc"}, CorrectPCE, cpc);
  endtask

  initial begin
    CPU_RSTn = 1'b0;
    PCF = 32'h100;
    idle();
    #2;
    cnts("reset", 32'd0, 32'd0);
    look("reset", 32'h100, 1'b0, 32'h0);
    @(negedge CLK);
    CPU_RSTn = 1'b1;
    tick();

    // Cold start: taken BEQ allocates; same-cycle lookup still sees the old table.
    look("cold_pre", 32'h100, 1'b0, 32'h0);
    ex(1'b1, 1'b0, 32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h0);
    redir("cold", 1'b1, 32'h200);
    look("cold_same", 32'h100, 1'b0, 32'h0);
    tick();
    idle();
    look("cold_post", 32'h100, 1'b1, 32'h200);
    cnts("cold", 32'd1, 32'd1);
    look("other_idx", 32'h104, 1'b0, 32'h0);

    // Three more taken: 10 -> 11 -> 11 -> 11, no mispredicts.
    for (int i = 0; i < 3; i++) begin
      ex(1'b1, 1'b0, 32'h100, 3'd1, 1'b1, 32'h200, 1'b1, 32'h200);
      redir("sat_tk", 1'b0, 32'h0);
      tick();
    end
    idle();
    cnts("sat", 32'd4, 32'd1);

    // Not taken once: 11 -> 10 still predicts taken.
    ex(1'b1, 1'b0, 32'h100, 3'd1, 1'b0, 32'h200, 1'b1, 32'h200);
    redir("nt1", 1'b1, 32'h104);
    tick();
    idle();
    look("nt1", 32'h100, 1'b1, 32'h200);
    // Not taken twice: 10 -> 01 predicts not taken.
    ex(1'b1, 1'b0, 32'h100, 3'd1, 1'b0, 32'h200, 1'b1, 32'h200);
    tick();
    idle();
    look("nt2", 32'h100, 1'b0, 32'h0);
    cnts("nt2", 32'd6, 32'd3);

    // Retrain to taken (01 -> 10), then change target.
    ex(1'b1, 1'b0, 32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    idle();
    look("retrain", 32'h100, 1'b1, 32'h200);
    ex(1'b1, 1'b0, 32'h100, 3'd1, 1'b1, 32'h300, 1'b1, 32'h200);
    redir("tgtchg", 1'b1, 32'h300);
    tick();
    idle();
    look("tgtchg", 32'h100, 1'b1, 32'h300);
    cnts("tgtchg", 32'd8, 32'd5);

    // Non-branch predicted taken: redirect to PC+4 and invalidate.
    ex(1'b1, 1'b0, 32'h100, 3'd0, 1'b0, 32'h0, 1'b1, 32'h300);
    redir("nobr", 1'b1, 32'h104);
    tick();
    idle();
    look("nobr", 32'h100, 1'b0, 32'h0);
    cnts("nobr", 32'd8, 32'd6);

    // Alias at 0x140 takes index 0; then 0x100 replaces it back.
    ex(1'b1, 1'b0, 32'h140, 3'd1, 1'b1, 32'h400, 1'b0, 32'h0);
    tick();
    idle();
    look("alias_new", 32'h140, 1'b1, 32'h400);
    look("alias_old", 32'h100, 1'b0, 32'h0);
    ex(1'b1, 1'b0, 32'h100, 3'd1, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    idle();
    look("repl_new", 32'h100, 1'b1, 32'h500);
    look("repl_old", 32'h140, 1'b0, 32'h0);
    cnts("repl", 32'd10, 32'd8);

    // Not-taken miss does not allocate over the live entry.
    ex(1'b1, 1'b0, 32'h180, 3'd2, 1'b0, 32'h600, 1'b0, 32'h0);
    redir("ntmiss", 1'b0, 32'h0);
    tick();
    idle();
    look("ntmiss_keep", 32'h100, 1'b1, 32'h500);
    look("ntmiss_none", 32'h180, 1'b0, 32'h0);
    cnts("ntmiss", 32'd11, 32'd8);

    // Stall and bubble leave everything alone.
    ex(1'b1, 1'b1, 32'h100, 3'd1, 1'b1, 32'h600, 1'b0, 32'h0);
    redir("stall", 1'b1, 32'h600);
    tick();
    ex(1'b0, 1'b0, 32'h100, 3'd1, 1'b1, 32'h600, 1'b0, 32'h0);
    redir("bubble", 1'b0, 32'h0);
    tick();
    idle();
    look("stall", 32'h100, 1'b1, 32'h500);
    cnts("stall", 32'd11, 32'd8);

    // Async reset mid-cycle with an update pending.
    ex(1'b1, 1'b0, 32'h200, 3'd1, 1'b1, 32'h700, 1'b0, 32'h0);
    #2;
    CPU_RSTn = 1'b0;
    #1;
    cnts("arst", 32'd0, 32'd0);
    look("arst", 32'h100, 1'b0, 32'h0);
    tick();
    @(negedge CLK);
    CPU_RSTn = 1'b1;
    idle();
    look("post_rst_100", 32'h100, 1'b0, 32'h0);
    look("post_rst_200", 32'h200, 1'b0, 32'h0);
    tick();
    cnts("post_rst", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4, log2 of BTB entry count (16 entries); index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2].
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 CPU_RSTn  input  1  reset, asynchronous, active-low.
REQ-004 PCF  input  32  fetch-stage PC for lookup.
REQ-005 PredTakenF  output  1  predicted taken for PCF.
REQ-006 PredTargetF  output  32  predicted target for PCF; 0 when PredTakenF=0.
REQ-007 ValidE  input  1  EX-stage instruction is valid (not a bubble).
REQ-008 StallE  input  1  EX stage held this cycle.
REQ-009 PCE  input  32  EX-stage PC.
REQ-010 BranchTypeE  input  3  branch type from Parameters.v; `NOBRANCH (3'd0) = not a branch.
REQ-011 BranchE  input  1  resolved outcome from branch decision logic.
REQ-012 BrTargetE  input  32  resolved branch target.
REQ-013 PredTakenE, PredTargetE  input  1, 32  prediction made for this instruction, piped from IF.
REQ-014 MispredE  output  1  redirect/flush request.
REQ-015 CorrectPCE  output  32  redirect PC, valid when MispredE=1.
REQ-016 BrCount, MispCount  output  32 each  resolved-branch and mispredict statistics.

Function
REQ-017 Each entry SHALL hold valid bit, tag, 32-bit target, 2-bit saturating counter.
REQ-018 Lookup SHALL be combinational: hit = valid & tag match; PredTakenF = hit & ctr[1]; PredTargetF = target when PredTakenF, else 0.
REQ-019 Update enable upd = ValidE & ~StallE; no table or statistic change when upd=0.
REQ-020 MispredE (combinational, gated by ValidE) SHALL be 1 when: branch and BranchE != PredTakenE; or branch, BranchE=1, PredTakenE=1, PredTargetE != BrTargetE; or non-branch with PredTakenE=1.
REQ-021 CorrectPCE SHALL be BrTargetE when branch and BranchE=1, else PCE+4 (32-bit wrap).
REQ-022 Branch with upd=1, hit: counter +1 saturating at 2'b11 if BranchE, -1 saturating at 2'b00 otherwise; target overwritten with BrTargetE if BranchE.
REQ-023 Branch with upd=1, miss, BranchE=1: allocate (overwrite) entry: valid=1, tag, target=BrTargetE, ctr=2'b10.
REQ-024 Branch with upd=1, miss, BranchE=0: no allocation.
REQ-025 Non-branch with upd=1 and hit on PCE SHALL clear that entry's valid bit.
REQ-026 Same-index lookup and update in one cycle: lookup SHALL return pre-edge contents; new contents visible next cycle.
REQ-027 BrCount +1 per branch with upd=1; MispCount +1 per upd=1 with MispredE=1; both saturate at 32'hFFFFFFFF.
REQ-028 Latency: prediction 0 cycles; table update visible 1 cycle after the upd edge.

Reset
REQ-029 CPU_RSTn=0 SHALL immediately clear all valid bits, targets to 0, counters to 2'b01, BrCount/MispCount to 0, independent of CLK.
REQ-030 Reset asserted mid-update SHALL discard that update; after deassertion first lookup SHALL miss (PredTakenF=0, PredTargetF=0).
REQ-031 MispredE/CorrectPCE are combinational and need no reset value beyond gating by ValidE.

Verification
REQ-032 Cold start: reset, PCF=0x100 -> PredTakenF=0; resolve BEQ at PCE=0x100, BranchE=1, BrTargetE=0x200, PredTakenE=0 -> MispredE=1, CorrectPCE=0x200; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x200, ctr=2'b10.
REQ-033 Saturation: same branch taken 3 more times -> ctr=2'b11; then not-taken once -> PredTakenF=1 still; twice -> PredTakenF=0.
REQ-034 Target change: hit taken entry, BranchE=1, BrTargetE=0x300, PredTargetE=0x200 -> MispredE=1, CorrectPCE=0x300; entry target becomes 0x300.
REQ-035 Alias/non-branch: PCE=0x100 with BranchTypeE=NOBRANCH, PredTakenE=1 -> MispredE=1, CorrectPCE=0x104, entry invalidated; PCE=0x140 (same index, new tag) taken -> replaces entry.
REQ-036 Stall/bubble: StallE=1 or ValidE=0 with branch inputs -> BrCount, MispCount, table unchanged; async reset pulse mid-cycle -> all stats 0, PCF=0x100 misses.
